// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared widths, RAM depth and command type for the two-requester on-chip RAM arbiter.
// Optional statistics counters in the top are enabled by ONCHIP_MEM_ARB_STATS_EN.
package onchip_mem_arb_pkg;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;
    localparam int BE_W      = DATA_W / 8;
    localparam int NUM_WORDS = 97500;

    // Depth in address width, so range checks need no widening.
    localparam logic [ADDR_W-1:0] NUM_WORDS_A = ADDR_W'(NUM_WORDS);

    // Requester index: 0 = m0, 1 = m1.
    typedef logic req_idx_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic              write;
        logic [DATA_W-1:0] writedata;
    } mem_cmd_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < NUM_WORDS_A;
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM-style requester bus and single-port RAM bus used by the arbiter.
// Handshake: a command is accepted on a clock edge where (read|write) is high and waitrequest is low;
// while waitrequest is high the requester holds address/byteenable/read/write/writedata stable.
// readdatavalid is a one-cycle strobe; readdata is meaningful only while it is high.
interface onchip_mem_arbiter_if;
    import onchip_mem_arb_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

interface onchip_mem_ram_if;
    import onchip_mem_arb_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last_grant register steers conflicts.
// last_grant resets to 1 so requester 0 wins the first conflict.
module rr_arb2
    import onchip_mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic     grant_any,
    output req_idx_t grant_idx
);

    req_idx_t last_grant;

    always_comb begin
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

    assign grant_any = |req;
    assign grant     = grant_any ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_any) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM (1-cycle read latency) between requesters m0 and m1.
// Define ONCHIP_MEM_ARB_STATS_EN to add grant/conflict counters with a synchronous clear.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    onchip_mem_ram_if.master      mem
`ifdef ONCHIP_MEM_ARB_STATS_EN
    ,
    input  logic                  stat_clear,
    output logic [31:0]           stat_grant0,
    output logic [31:0]           stat_grant1,
    output logic [31:0]           stat_conflict
`endif
);

    logic [1:0] req;
    logic [1:0] grant;
    logic       grant_any;
    req_idx_t   grant_idx;
    mem_cmd_t   cmd0;
    mem_cmd_t   cmd1;
    mem_cmd_t   cmd_sel;
    logic       in_range;

    logic [ADDR_W-1:0] hold_address;
    logic [BE_W-1:0]   hold_byteenable;
    logic [DATA_W-1:0] hold_writedata;

    logic       rd_pend;
    req_idx_t   rd_owner;
    logic       rd_oor;
    logic [DATA_W-1:0] rd_data;

    // Requests are masked during reset so nothing is granted or issued.
    assign req[0] = (m0.read | m0.write) & ~reset;
    assign req[1] = (m1.read | m1.write) & ~reset;

    always_comb begin
        cmd0.address    = m0.address;
        cmd0.byteenable = m0.byteenable;
        cmd0.write      = m0.write;
        cmd0.writedata  = m0.writedata;
        cmd1.address    = m1.address;
        cmd1.byteenable = m1.byteenable;
        cmd1.write      = m1.write;
        cmd1.writedata  = m1.writedata;
    end

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (reset),
        .req       (req),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    assign cmd_sel  = grant_idx ? cmd1 : cmd0;
    assign in_range = addr_in_range(cmd_sel.address);

    assign m0.waitrequest = reset | (req[0] & ~grant[0]);
    assign m1.waitrequest = reset | (req[1] & ~grant[1]);

    // Idle cycles keep the RAM bus at the last granted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_address    <= '0;
            hold_byteenable <= '0;
            hold_writedata  <= '0;
        end else if (grant_any) begin
            hold_address    <= cmd_sel.address;
            hold_byteenable <= cmd_sel.byteenable;
            hold_writedata  <= cmd_sel.writedata;
        end
    end

    assign mem.address    = grant_any ? cmd_sel.address    : hold_address;
    assign mem.byteenable = grant_any ? cmd_sel.byteenable : hold_byteenable;
    assign mem.writedata  = grant_any ? cmd_sel.writedata  : hold_writedata;
    assign mem.chipselect = grant_any & in_range;
    assign mem.write      = grant_any & cmd_sel.write & in_range;
    assign mem.clken      = 1'b1;

    // Write wins over read, so only a pure read schedules a data return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
            rd_oor   <= 1'b0;
        end else begin
            rd_pend  <= grant_any & ~cmd_sel.write;
            rd_owner <= grant_idx;
            rd_oor   <= ~in_range;
        end
    end

    assign rd_data = rd_oor ? '0 : mem.readdata;

    assign m0.readdatavalid = rd_pend & ~rd_owner;
    assign m1.readdatavalid = rd_pend &  rd_owner;
    assign m0.readdata      = m0.readdatavalid ? rd_data : '0;
    assign m1.readdata      = m1.readdatavalid ? rd_data : '0;

`ifdef ONCHIP_MEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else if (stat_clear) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (grant[0]) stat_grant0   <= stat_grant0 + 32'd1;
            if (grant[1]) stat_grant1   <= stat_grant1 + 32'd1;
            if (&req)     stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios with literal checks, then random traffic
// compared every cycle against a queue-based model; statistics checked when ONCHIP_MEM_ARB_STATS_EN is set.
module tb_onchip_mem_arbiter;
    import onchip_mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic stat_clear;

    always #5 clk = ~clk;

    onchip_mem_arbiter_if m0 ();
    onchip_mem_arbiter_if m1 ();
    onchip_mem_ram_if     mem ();

`ifdef ONCHIP_MEM_ARB_STATS_EN
    logic [31:0] stat_grant0;
    logic [31:0] stat_grant1;
    logic [31:0] stat_conflict;
`endif

    onchip_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0),
        .m1    (m1),
        .mem   (mem)
`ifdef ONCHIP_MEM_ARB_STATS_EN
        ,
        .stat_clear    (stat_clear),
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
`endif
    );

    // RAM behaviour and golden contents
    logic [31:0] ram  [0:131071];
    logic [31:0] gold [0:131071];

    always @(posedge clk) begin
        if (mem.clken && mem.chipselect) begin
            if (mem.write) begin
                for (int b = 0; b < 4; b++)
                    if (mem.byteenable[b]) ram[mem.address][8*b +: 8] <= mem.writedata[8*b +: 8];
            end else begin
                mem.readdata <= ram[mem.address];
            end
        end
    end

    // Scoreboard
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] exp_q[$];
    logic        own_q[$];
    logic        lg_m;
    logic        hold_v;
    logic [16:0] hold_a;
    int unsigned cnt_g0, cnt_g1, cnt_cf;

    always @(negedge clk) begin : model
        logic        r0, r1, w, own, v0, v1;
        int          g;
        logic [16:0] a;
        logic [3:0]  be;
        logic [31:0] wd, d0, d1, d;
        logic        inr;
        if (reset) begin
            exp_q.delete();
            own_q.delete();
            lg_m   = 1'b1;
            hold_v = 1'b0;
            cnt_g0 = 0; cnt_g1 = 0; cnt_cf = 0;
            chk1("rst_wait0", m0.waitrequest, 1'b1);
            chk1("rst_wait1", m1.waitrequest, 1'b1);
            chk1("rst_cs", mem.chipselect, 1'b0);
            chk1("rst_rdv0", m0.readdatavalid, 1'b0);
            chk1("rst_rdv1", m1.readdatavalid, 1'b0);
            chk32("rst_rd0", m0.readdata, 32'h0);
            chk32("rst_rd1", m1.readdata, 32'h0);
`ifdef ONCHIP_MEM_ARB_STATS_EN
            chk32("rst_sg0", stat_grant0, 32'h0);
            chk32("rst_sg1", stat_grant1, 32'h0);
            chk32("rst_scf", stat_conflict, 32'h0);
`endif
        end else begin
            r0 = m0.read | m0.write;
            r1 = m1.read | m1.write;
            g = -1;
            if (r0 && r1) g = lg_m ? 0 : 1;
            else if (r0) g = 0;
            else if (r1) g = 1;
            chk1("m_wait0", m0.waitrequest, r0 && g != 0);
            chk1("m_wait1", m1.waitrequest, r1 && g != 1);
            a = 0; be = 0; wd = 0; w = 0; inr = 0;
            if (g >= 0) begin
                a   = (g == 1) ? m1.address    : m0.address;
                be  = (g == 1) ? m1.byteenable : m0.byteenable;
                wd  = (g == 1) ? m1.writedata  : m0.writedata;
                w   = (g == 1) ? m1.write      : m0.write;
                inr = (int'(a) < NUM_WORDS);
                chk1("m_cs", mem.chipselect, inr);
                chk1("m_memwr", mem.write, w && inr);
                chk32("m_addr", 32'(mem.address), 32'(a));
                if (w && inr) begin
                    chk32("m_be", 32'(mem.byteenable), 32'(be));
                    chk32("m_wd", mem.writedata, wd);
                end
            end else begin
                chk1("m_cs_idle", mem.chipselect, 1'b0);
                chk1("m_memwr_idle", mem.write, 1'b0);
                if (hold_v) chk32("m_addr_hold", 32'(mem.address), 32'(hold_a));
            end
            v0 = 0; v1 = 0; d0 = 0; d1 = 0;
            if (exp_q.size() > 0) begin
                own = own_q.pop_front();
                d   = exp_q.pop_front();
                if (own) begin v1 = 1; d1 = d; end
                else     begin v0 = 1; d0 = d; end
            end
            chk1("m_rdv0", m0.readdatavalid, v0);
            chk1("m_rdv1", m1.readdatavalid, v1);
            chk32("m_rd0", m0.readdata, d0);
            chk32("m_rd1", m1.readdata, d1);
`ifdef ONCHIP_MEM_ARB_STATS_EN
            chk32("m_sg0", stat_grant0, cnt_g0);
            chk32("m_sg1", stat_grant1, cnt_g1);
            chk32("m_scf", stat_conflict, cnt_cf);
`endif
            // advance to the next clock edge
            if (g >= 0) begin
                lg_m   = g[0];
                hold_v = 1'b1;
                hold_a = a;
                if (w && inr) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) gold[a][8*b +: 8] = wd[8*b +: 8];
                end else if (!w) begin
                    exp_q.push_back(inr ? gold[a] : 32'h0);
                    own_q.push_back(g[0]);
                end
            end
            if (stat_clear) begin
                cnt_g0 = 0; cnt_g1 = 0; cnt_cf = 0;
            end else begin
                if (g == 0) cnt_g0++;
                if (g == 1) cnt_g1++;
                if (r0 && r1) cnt_cf++;
            end
        end
    end

    // Driver tasks
    task automatic set_cmd(input int n, input logic rd, input logic wr, input logic [16:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        if (n == 0) begin
            m0.read = rd; m0.write = wr; m0.address = a; m0.byteenable = be; m0.writedata = wd;
        end else begin
            m1.read = rd; m1.write = wr; m1.address = a; m1.byteenable = be; m1.writedata = wd;
        end
    endtask

    task automatic idle(input int n);
        set_cmd(n, 1'b0, 1'b0, 17'h0, 4'h0, 32'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic rand_cmd(input int n);
        int          kind, sel;
        logic [16:0] a;
        kind = $urandom_range(0, 9);
        sel  = $urandom_range(0, 3);
        case (sel)
            0:       a = 17'($urandom_range(0, 15));
            1:       a = 17'($urandom_range(97495, 97505));
            2:       a = 17'($urandom_range(0, 131071));
            default: a = 17'($urandom_range(32, 47));
        endcase
        set_cmd(n, kind >= 4 && kind <= 6 || kind == 9, kind >= 7, a,
                4'($urandom_range(0, 15)), $urandom);
    endtask

    initial begin
        logic w0_s, w1_s;
        for (int i = 0; i < 131072; i++) begin
            ram[i]  = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
            gold[i] = ram[i];
        end
        ram[16]    = 32'hCAFEF00D; gold[16]    = 32'hCAFEF00D;
        ram[32]    = 32'hAAAAAAAA; gold[32]    = 32'hAAAAAAAA;
        ram[97499] = 32'h5555AAAA; gold[97499] = 32'h5555AAAA;
        reset = 1'b1;
        stat_clear = 1'b0;
        idle(0);
        idle(1);
        repeat (3) next();
        reset = 1'b0;
        mid();

        // single read
        next(); set_cmd(0, 1, 0, 17'h00010, 4'hF, 0); mid();
        chk1("sr_wait0", m0.waitrequest, 1'b0);
        chk1("sr_cs", mem.chipselect, 1'b1);
        next(); idle(0); mid();
        chk1("sr_rdv0", m0.readdatavalid, 1'b1);
        chk32("sr_data0", m0.readdata, 32'hCAFEF00D);
        chk1("sr_rdv1", m1.readdatavalid, 1'b0);
        chk32("sr_data1", m1.readdata, 32'h0);

        // reset while an m1 read is in flight
        next(); set_cmd(1, 1, 0, 17'h00030, 4'hF, 0); mid();
        chk1("rm_wait1", m1.waitrequest, 1'b0);
        next(); idle(1); reset = 1'b1; mid();
        chk1("rm_rdv1_in", m1.readdatavalid, 1'b0);
        next(); mid();
        next(); reset = 1'b0; mid();
        chk1("rm_rdv1_after", m1.readdatavalid, 1'b0);

        // conflict: grants alternate starting with m0
        next(); set_cmd(0, 1, 0, 17'h100, 4'hF, 0); set_cmd(1, 1, 0, 17'h200, 4'hF, 0); mid();
        chk1("cf1_wait0", m0.waitrequest, 1'b0); chk1("cf1_wait1", m1.waitrequest, 1'b1);
        next(); set_cmd(0, 1, 0, 17'h101, 4'hF, 0); mid();
        chk1("cf2_wait0", m0.waitrequest, 1'b1); chk1("cf2_wait1", m1.waitrequest, 1'b0);
        chk1("cf2_rdv0", m0.readdatavalid, 1'b1);
        next(); set_cmd(1, 1, 0, 17'h201, 4'hF, 0); mid();
        chk1("cf3_wait0", m0.waitrequest, 1'b0); chk1("cf3_wait1", m1.waitrequest, 1'b1);
        chk1("cf3_rdv1", m1.readdatavalid, 1'b1);
        next(); set_cmd(0, 1, 0, 17'h102, 4'hF, 0); mid();
        chk1("cf4_wait0", m0.waitrequest, 1'b1); chk1("cf4_wait1", m1.waitrequest, 1'b0);
        chk1("cf4_rdv0", m0.readdatavalid, 1'b1);
        next(); idle(1); mid();
        chk1("cf5_wait0", m0.waitrequest, 1'b0);
        chk1("cf5_rdv1", m1.readdatavalid, 1'b1);
`ifdef ONCHIP_MEM_ARB_STATS_EN
        chk32("cf_sg0", stat_grant0, 32'd2);
        chk32("cf_sg1", stat_grant1, 32'd2);
        chk32("cf_scf", stat_conflict, 32'd4);
`endif
        next(); idle(0); stat_clear = 1'b1; mid();
        chk1("cf6_rdv0", m0.readdatavalid, 1'b1);
        next(); stat_clear = 1'b0; mid();
`ifdef ONCHIP_MEM_ARB_STATS_EN
        chk32("clr_sg0", stat_grant0, 32'd0);
        chk32("clr_sg1", stat_grant1, 32'd0);
        chk32("clr_scf", stat_conflict, 32'd0);
`endif

        // partial write then read-back
        next(); set_cmd(1, 0, 1, 17'h00020, 4'b0011, 32'h12345678); mid();
        chk1("wr_memwr", mem.write, 1'b1);
        next(); set_cmd(1, 1, 0, 17'h00020, 4'hF, 0); mid();
        next(); idle(1); mid();
        chk1("wr_rdv1", m1.readdatavalid, 1'b1);
        chk32("wr_data1", m1.readdata, 32'hAAAA5678);

        // out of range
        next(); set_cmd(0, 0, 1, 17'd97500, 4'hF, 32'hFFFFFFFF); mid();
        chk1("oor_wait0", m0.waitrequest, 1'b0);
        chk1("oor_cs_w", mem.chipselect, 1'b0);
        next(); set_cmd(0, 1, 0, 17'd97500, 4'hF, 0); mid();
        chk1("oor_cs_r", mem.chipselect, 1'b0);
        next(); set_cmd(0, 1, 0, 17'd97499, 4'hF, 0); mid();
        chk1("oor_rdv0", m0.readdatavalid, 1'b1);
        chk32("oor_data0", m0.readdata, 32'h0);
        next(); idle(0); mid();
        chk32("oor_neighbour", m0.readdata, 32'h5555AAAA);

        // random traffic, holding commands while waitrequest is high
        w0_s = 1'b0;
        w1_s = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            next();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            stat_clear = ($urandom_range(0, 99) == 0);
            if (!w0_s) rand_cmd(0);
            if (!w1_s) rand_cmd(1);
            mid();
            w0_s = m0.waitrequest;
            w1_s = m1.waitrequest;
        end
        next(); idle(0); idle(1); stat_clear = 1'b0; reset = 1'b0;
        repeat (3) next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
